// File: rtl/knn_pkg.sv
// Shared types for the kNN distance pipeline: FSM state encoding and the
// result entry produced by each bit-serial distance unit.
package knn_pkg;

    localparam int KNN_D         = 3;
    localparam int KNN_BIT_WIDTH = 32;
    localparam int KNN_DIST_W    = 2*KNN_BIT_WIDTH + $clog2(KNN_D+1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bdu_state_e;

    // A unit instantiated with narrower D/BIT_WIDTH zero-extends into these fields.
    typedef struct packed {
        logic                                   valid;
        logic [KNN_DIST_W-1:0]                  distance;
        logic [KNN_D-1:0][KNN_BIT_WIDTH-1:0]    coords;
    } knn_entry_t;

endpackage

// File: rtl/bdu_lb.sv
// Lower bound on the final squared distance given the signed prefix
// differences f[] after k of BIT_WIDTH bit positions. Each lane contributes
// max(|f|-1,0)^2 * 4^(BIT_WIDTH-k); the remaining low bits can shrink a
// difference by at most one prefix unit.
module bdu_lb
    import knn_pkg::*;
#(
    parameter int D         = 3,
    parameter int BIT_WIDTH = 32,
    parameter int DIST_W    = 2*BIT_WIDTH + $clog2(D+1),
    parameter int KW        = $clog2(BIT_WIDTH+1)
) (
    input  logic [D-1:0][BIT_WIDTH+1:0] f,
    input  logic [KW-1:0]               k,
    input  logic [DIST_W-1:0]           threshold,
    output logic                        lb_hit
);

    localparam int FW = BIT_WIDTH + 2;

    logic [KW-1:0]              rem_bits;
    logic [KW:0]                shamt;
    logic                       k_in_range;
    logic [D-1:0][DIST_W-1:0]   lane_term;
    logic [DIST_W-1:0]          lb_sum;

    // Remaining bit positions, and whether the bound is meaningful at all.
    always_comb begin
        rem_bits   = KW'(BIT_WIDTH) - k;
        shamt      = {rem_bits, 1'b0};
        k_in_range = (k != '0) && (k < KW'(BIT_WIDTH));
    end

    for (genvar g = 0; g < D; g++) begin : g_lane
        logic [FW-1:0]     mag;
        logic [FW-1:0]     mag_m1;
        logic [DIST_W-1:0] sq;

        assign mag          = f[g][FW-1] ? (~f[g] + FW'(1)) : f[g];
        assign mag_m1       = (mag == '0) ? '0 : (mag - FW'(1));
        assign sq           = DIST_W'(mag_m1) * DIST_W'(mag_m1);
        assign lane_term[g] = sq << shamt;
    end

    // Sum the lanes and compare against the current kth distance.
    always_comb begin
        lb_sum = '0;
        for (int i = 0; i < D; i++) begin
            lb_sum = lb_sum + lane_term[i];
        end
        lb_hit = k_in_range && (lb_sum >= threshold);
    end

endmodule

// File: rtl/bdu_ndim.sv
// Bit-serial squared-Euclidean distance unit. Query/reference bit pairs
// arrive MSB-first, interleaved across dimensions; the exact distance is
// built incrementally and the point is abandoned early once a lower bound
// proves it cannot beat the latched threshold.
//
// Handshakes: a bit pair transfers on a cycle where in_valid && in_ready;
// a result transfers on a cycle where out_valid && out_ready. Neither ready
// nor valid depends combinationally on its partner, and a presented result
// holds stable until it transfers.
module bdu_ndim
    import knn_pkg::*;
#(
    parameter  int D         = 3,
    parameter  int BIT_WIDTH = 32,
    localparam int DIST_W    = 2*BIT_WIDTH + $clog2(D+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] threshold,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              q_bit,
    input  logic              r_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output knn_entry_t        bdu_out,
    output logic              terminated,
    output bdu_state_e        dbg_state
);

    localparam int FW  = BIT_WIDTH + 2;
    localparam int PW  = DIST_W + 2;
    localparam int DCW = (D > 1) ? $clog2(D) : 1;
    localparam int KW  = $clog2(BIT_WIDTH+1);

    bdu_state_e                     state_q, state_d;
    logic [DIST_W-1:0]              thr_q, thr_d;
    logic [D-1:0][FW-1:0]           f_q, f_d;
    logic [DIST_W-1:0]              p_q, p_d;
    logic [D-1:0][BIT_WIDTH-1:0]    coords_q, coords_d;
    logic [DCW-1:0]                 d_ctr_q, d_ctr_d;
    logic [KW-1:0]                  b_ctr_q, b_ctr_d;
    logic                           valid_q, valid_d;
    logic                           term_q, term_d;

    logic                lb_raw;
    logic                lb_hit;
    logic [FW-1:0]       f_sel;
    logic [FW-1:0]       f_new;
    logic [PW-1:0]       f4;
    logic [PW-1:0]       incr;
    logic [PW-1:0]       p_base;
    logic [PW-1:0]       p_sum;
    logic [DIST_W-1:0]   p_next;
    logic [BIT_WIDTH:0]  coord_cat;
    logic                e_pos;
    logic                e_neg;
    logic                last_beat;

    bdu_lb #(
        .D         (D),
        .BIT_WIDTH (BIT_WIDTH),
        .DIST_W    (DIST_W),
        .KW        (KW)
    ) u_lb (
        .f         (f_q),
        .k         (b_ctr_q),
        .threshold (thr_q),
        .lb_hit    (lb_raw)
    );

    // Bound is only checked at a bit-position boundary while running.
    assign lb_hit = (state_q == ST_RUN) && (d_ctr_q == '0) && lb_raw;

    // Per-beat datapath: e = q - r, f' = 2f + e, P grows by 4fe + e^2
    // (P is first scaled by 4 at the start of every bit position).
    always_comb begin
        e_pos     = q_bit & ~r_bit;
        e_neg     = ~q_bit & r_bit;
        f_sel     = f_q[d_ctr_q];
        f_new     = (f_sel << 1) + (e_pos ? FW'(1) : (e_neg ? {FW{1'b1}} : '0));
        f4        = {{(PW-FW){f_sel[FW-1]}}, f_sel} << 2;
        incr      = e_pos ? (f4 + PW'(1)) : (e_neg ? (PW'(1) - f4) : '0);
        p_base    = (d_ctr_q == '0) ? {p_q, 2'b00} : {2'b00, p_q};
        p_sum     = p_base + incr;
        p_next    = p_sum[DIST_W-1:0];
        coord_cat = {coords_q[d_ctr_q], r_bit};
        last_beat = (d_ctr_q == DCW'(D-1)) && (b_ctr_q == KW'(BIT_WIDTH-1));
    end

    // Next-state and handshake logic; flush overrides every other event.
    always_comb begin
        state_d   = state_q;
        thr_d     = thr_q;
        f_d       = f_q;
        p_d       = p_q;
        coords_d  = coords_q;
        d_ctr_d   = d_ctr_q;
        b_ctr_d   = b_ctr_q;
        valid_d   = valid_q;
        term_d    = term_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d    = threshold;
                    f_d      = '0;
                    p_d      = '0;
                    coords_d = '0;
                    d_ctr_d  = '0;
                    b_ctr_d  = '0;
                    valid_d  = 1'b0;
                    term_d   = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = !lb_hit;
                if (lb_hit) begin
                    state_d = ST_DONE;
                    term_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (in_valid) begin
                    f_d[d_ctr_q]      = f_new;
                    p_d               = p_next;
                    coords_d[d_ctr_q] = coord_cat[BIT_WIDTH-1:0];
                    if (d_ctr_q == DCW'(D-1)) begin
                        d_ctr_d = '0;
                        b_ctr_d = b_ctr_q + KW'(1);
                    end else begin
                        d_ctr_d = d_ctr_q + DCW'(1);
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                        term_d  = 1'b0;
                        valid_d = (p_next < thr_q);
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    f_d      = '0;
                    p_d      = '0;
                    coords_d = '0;
                    d_ctr_d  = '0;
                    b_ctr_d  = '0;
                    valid_d  = 1'b0;
                    term_d   = 1'b0;
                    if (start) begin
                        thr_d   = threshold;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            thr_d    = '0;
            f_d      = '0;
            p_d      = '0;
            coords_d = '0;
            d_ctr_d  = '0;
            b_ctr_d  = '0;
            valid_d  = 1'b0;
            term_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            thr_q    <= '0;
            f_q      <= '0;
            p_q      <= '0;
            coords_q <= '0;
            d_ctr_q  <= '0;
            b_ctr_q  <= '0;
            valid_q  <= 1'b0;
            term_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            thr_q    <= thr_d;
            f_q      <= f_d;
            p_q      <= p_d;
            coords_q <= coords_d;
            d_ctr_q  <= d_ctr_d;
            b_ctr_q  <= b_ctr_d;
            valid_q  <= valid_d;
            term_q   <= term_d;
        end
    end

    // Pack the registered result into the shared entry format.
    always_comb begin
        bdu_out          = '0;
        bdu_out.valid    = valid_q;
        bdu_out.distance = KNN_DIST_W'(p_q);
        for (int i = 0; i < D; i++) begin
            bdu_out.coords[i] = KNN_BIT_WIDTH'(coords_q[i]);
        end
    end

    assign terminated = term_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bdu_ndim.sv
// Directed bench for bdu_ndim with D=3, BIT_WIDTH=8 and in_valid held high
// while feeding a point.
module tb_bdu_ndim;
    import knn_pkg::*;

    localparam int D      = 3;
    localparam int BW     = 8;
    localparam int DIST_W = 2*BW + $clog2(D+1);

    logic              clk;
    logic              rst;
    logic              start;
    logic [DIST_W-1:0] threshold;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              q_bit;
    logic              r_bit;
    logic              out_valid;
    logic              out_ready;
    knn_entry_t        bdu_out;
    logic              terminated;
    bdu_state_e        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] qv [D];
    logic [BW-1:0] rv [D];

    bdu_ndim #(.D(D), .BIT_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .threshold  (threshold),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .q_bit      (q_bit),
        .r_bit      (r_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bdu_out    (bdu_out),
        .terminated (terminated),
        .dbg_state  (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_point(input logic [BW-1:0] q0, q1, q2, r0, r1, r2);
        qv[0] = q0; qv[1] = q1; qv[2] = q2;
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
    endtask

    // Present beats with in_valid high until limit accepts or a result appears.
    task automatic run_beats(input int limit, output int beats, output bit got_out);
        int  idx;
        int  bp;
        int  dd;
        bit  acc;
        idx     = 0;
        got_out = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (out_valid) begin
                got_out = 1'b1;
                break;
            end
            if (idx >= limit) break;
            if (idx < D*BW) begin
                bp    = BW - 1 - idx / D;
                dd    = idx % D;
                q_bit = qv[dd][bp];
                r_bit = rv[dd][bp];
            end else begin
                q_bit = 1'b0;
                r_bit = 1'b0;
            end
            in_valid = 1'b1;
            acc      = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        beats    = idx;
    endtask

    task automatic start_run(input logic [DIST_W-1:0] thr);
        start     = 1'b1;
        threshold = thr;
        tick();
        start     = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b0; threshold = 18'd5;
        in_valid = 1'b0; out_ready = 1'b0; q_bit = 1'b0; r_bit = 1'b0;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (terminated !== 1'b0) begin bad++; $display("FAIL rst_terminated got=%b want=0", terminated); end
        total++; if (bdu_out !== '0) begin bad++; $display("FAIL rst_bdu_out got=%h want=0", bdu_out); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        rst = 1'b0; start = 1'b0;
        tick();
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL post_rst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_exact_in();
        int beats; bit got;
        set_point(8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run(18'd100);
        total++; if (dbg_state !== ST_RUN || in_ready !== 1'b1) begin bad++; $display("FAIL in_start got state=%0d rdy=%b want state=%0d rdy=1", dbg_state, in_ready, ST_RUN); end
        run_beats(1000, beats, got);
        total++; if (!got || beats != 24) begin bad++; $display("FAIL in_beats got=%0d out=%b want=24 out=1", beats, got); end
        total++; if (bdu_out.distance !== 25) begin bad++; $display("FAIL in_distance got=%0d want=25", bdu_out.distance); end
        total++; if (bdu_out.valid !== 1'b1 || terminated !== 1'b0) begin bad++; $display("FAIL in_flags got v=%b t=%b want v=1 t=0", bdu_out.valid, terminated); end
        total++; if (bdu_out.coords !== '0) begin bad++; $display("FAIL in_coords got=%h want=0", bdu_out.coords); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL in_done_ready got=%b want=0", in_ready); end
        ack();
        total++; if (dbg_state !== ST_IDLE || out_valid !== 1'b0) begin bad++; $display("FAIL in_ack got state=%0d ov=%b want state=%0d ov=0", dbg_state, out_valid, ST_IDLE); end
    endtask

    task automatic test_exact_out();
        int beats; bit got;
        set_point(8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run(18'd25);
        run_beats(1000, beats, got);
        total++; if (!got || beats != 24) begin bad++; $display("FAIL out_beats got=%0d out=%b want=24 out=1", beats, got); end
        total++; if (bdu_out.distance !== 25) begin bad++; $display("FAIL out_distance got=%0d want=25", bdu_out.distance); end
        total++; if (bdu_out.valid !== 1'b0 || terminated !== 1'b0) begin bad++; $display("FAIL out_flags got v=%b t=%b want v=0 t=0", bdu_out.valid, terminated); end
        ack();
    endtask

    task automatic test_coords();
        int beats; bit got;
        set_point(8'd10, 8'd200, 8'd7, 8'd13, 8'd190, 8'd7);
        start_run(18'd1000);
        run_beats(1000, beats, got);
        total++; if (!got || beats != 24) begin bad++; $display("FAIL crd_beats got=%0d out=%b want=24 out=1", beats, got); end
        total++; if (bdu_out.distance !== 109) begin bad++; $display("FAIL crd_distance got=%0d want=109", bdu_out.distance); end
        total++; if (bdu_out.valid !== 1'b1) begin bad++; $display("FAIL crd_valid got=%b want=1", bdu_out.valid); end
        total++; if (bdu_out.coords[0] !== 13 || bdu_out.coords[1] !== 190 || bdu_out.coords[2] !== 7) begin bad++; $display("FAIL crd_coords got=%0d,%0d,%0d want=13,190,7", bdu_out.coords[0], bdu_out.coords[1], bdu_out.coords[2]); end
        ack();
    endtask

    task automatic test_lb_term();
        int beats; bit got;
        set_point(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run(18'd100);
        run_beats(1000, beats, got);
        total++; if (!got || beats != 6) begin bad++; $display("FAIL lb_beats got=%0d out=%b want=6 out=1", beats, got); end
        total++; if (terminated !== 1'b1 || bdu_out.valid !== 1'b0) begin bad++; $display("FAIL lb_flags got t=%b v=%b want t=1 v=0", terminated, bdu_out.valid); end
        total++; if (bdu_out.distance !== 9) begin bad++; $display("FAIL lb_partial got=%0d want=9", bdu_out.distance); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL lb_hold got rdy=%b ov=%b want rdy=0 ov=1", in_ready, out_valid); end
        end
        in_valid = 1'b0;
        ack();
    endtask

    task automatic test_thr_zero();
        int beats; bit got;
        set_point(8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run(18'd0);
        run_beats(1000, beats, got);
        total++; if (!got || beats != 3) begin bad++; $display("FAIL thr0_beats got=%0d out=%b want=3 out=1", beats, got); end
        total++; if (terminated !== 1'b1 || bdu_out.distance !== 0) begin bad++; $display("FAIL thr0_result got t=%b d=%0d want t=1 d=0", terminated, bdu_out.distance); end
        ack();
    endtask

    task automatic test_flush();
        int beats; bit got;
        set_point(8'd10, 8'd200, 8'd7, 8'd13, 8'd190, 8'd7);
        start_run(18'd1000);
        run_beats(10, beats, got);
        total++; if (got || beats != 10) begin bad++; $display("FAIL fl_beats got=%0d out=%b want=10 out=0", beats, got); end
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (dbg_state !== ST_IDLE || out_valid !== 1'b0) begin bad++; $display("FAIL fl_state got state=%0d ov=%b want state=%0d ov=0", dbg_state, out_valid, ST_IDLE); end
        total++; if (bdu_out !== '0) begin bad++; $display("FAIL fl_cleared got=%h want=0", bdu_out); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_quiet got=%b want=0", out_valid); end
        end
    endtask

    task automatic test_hold();
        int beats; bit got;
        set_point(8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0);
        start_run(18'd1000);
        run_beats(1000, beats, got);
        total++; if (!got || beats != 24) begin bad++; $display("FAIL hold_beats got=%0d out=%b want=24 out=1", beats, got); end
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0; start = 1'b1; in_valid = 1'b1; threshold = 18'd7;
            tick();
            total++; if (out_valid !== 1'b1 || dbg_state !== ST_DONE) begin bad++; $display("FAIL hold_state got ov=%b state=%0d want ov=1 state=%0d", out_valid, dbg_state, ST_DONE); end
            total++; if (bdu_out.distance !== 25 || bdu_out.valid !== 1'b1 || terminated !== 1'b0) begin bad++; $display("FAIL hold_data got d=%0d v=%b t=%b want d=25 v=1 t=0", bdu_out.distance, bdu_out.valid, terminated); end
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int beats; bit got;
        set_point(8'd10, 8'd200, 8'd7, 8'd13, 8'd190, 8'd7);
        out_ready = 1'b1; start = 1'b1; threshold = 18'd100;
        tick();
        out_ready = 1'b0; start = 1'b0;
        total++; if (dbg_state !== ST_RUN || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_state got state=%0d ov=%b want state=%0d ov=0", dbg_state, out_valid, ST_RUN); end
        total++; if (bdu_out.distance !== 0) begin bad++; $display("FAIL b2b_cleared got=%0d want=0", bdu_out.distance); end
        run_beats(1000, beats, got);
        total++; if (!got || beats != 24) begin bad++; $display("FAIL b2b_beats got=%0d out=%b want=24 out=1", beats, got); end
        total++; if (bdu_out.distance !== 109 || bdu_out.valid !== 1'b0 || terminated !== 1'b0) begin bad++; $display("FAIL b2b_result got d=%0d v=%b t=%b want d=109 v=0 t=0", bdu_out.distance, bdu_out.valid, terminated); end
        total++; if (bdu_out.coords[1] !== 190) begin bad++; $display("FAIL b2b_coord got=%0d want=190", bdu_out.coords[1]); end
        ack();
    endtask

    task automatic test_mid_reset();
        int beats; bit got;
        set_point(8'd10, 8'd200, 8'd7, 8'd13, 8'd190, 8'd7);
        start_run(18'd1000);
        run_beats(5, beats, got);
        rst = 1'b1; flush = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        total++; if (dbg_state !== ST_IDLE || in_ready !== 1'b0) begin bad++; $display("FAIL mrst_state got state=%0d rdy=%b want state=%0d rdy=0", dbg_state, in_ready, ST_IDLE); end
        total++; if (bdu_out !== '0) begin bad++; $display("FAIL mrst_cleared got=%h want=0", bdu_out); end
    endtask

    initial begin
        test_reset();
        test_exact_in();
        test_exact_out();
        test_coords();
        test_lb_term();
        test_thr_zero();
        test_flush();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
